paddle_ctrl: RTL

- Per-player input-conditioning stage directly upstream of the pong core's paddle1_vpos/paddle2_vpos inputs; one instance per player.
- Turns raw analog stick data (axis select and inversion) and digital up/down buttons into one registered 8-bit paddle position.
- Digital mode uses a rate-limited, accelerating position integrator.
- Arbitrates automatically between analog and digital sources, so keyboard and d-pad players are supported without a menu option.

---
 rtl/paddle_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/paddle_ctrl.sv
// Per-player paddle input conditioning: analog stick mapping, accelerating digital
// integrator and automatic source arbitration. Optional IIR smoothing: PADDLE_FILTER_EN.
module paddle_ctrl #(
  parameter int STEP_DIV   = 1024,
  parameter int ACCEL_MAX  = 4,
  parameter int RAMP_TICKS = 16,
  parameter int DEADBAND   = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [15:0] analog_in,
  input  logic [1:0]  axis_sel,
  input  logic        joy_up,
  input  logic        joy_down,
  output logic [7:0]  vpos_out,
  output logic        src_digital
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int SW = $clog2(ACCEL_MAX + 1);
  localparam int RW = $clog2(RAMP_TICKS + 1);

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          src_q, src_d;
  logic [7:0]    vpos_q, vpos_d;
  logic [SW-1:0] step_q, step_d;
  logic [RW-1:0] ramp_q, ramp_d;
  logic [1:0]    dir_q, dir_d;
  logic [7:0]    aref_q, aref_d;

  logic              tick, btn, mv_up, mv_dn, dev_big, dir_chg;
  logic [7:0]        a;
  logic signed [8:0] adiff;
  logic [8:0]        adiff_abs;
  logic [1:0]        dir_new;
  logic [SW-1:0]     stp_eff;
  logic [RW-1:0]     ramp_inc;
  logic [8:0]        pos_sum, pos_dif;
`ifdef PADDLE_FILTER_EN
  logic signed [8:0] fdiff, fsh;
`endif

  always_comb begin
    case (axis_sel)
      2'b01:   a = analog_in[7:0] + 8'h80;
      2'b10:   a = analog_in[7:0] ^ 8'h7F;
      default: a = analog_in[15:8] + 8'h80;
    endcase
  end

  assign tick      = (cnt_q == CW'(STEP_DIV - 1));
  assign btn       = joy_up | joy_down;
  assign mv_up     = joy_up & ~joy_down;
  assign mv_dn     = joy_down & ~joy_up;
  assign adiff     = $signed({1'b0, a}) - $signed({1'b0, aref_q});
  assign adiff_abs = adiff[8] ? 9'(-adiff) : 9'(adiff);
  assign dev_big   = adiff_abs > 9'(DEADBAND);

  // A reversal (or first move after idle) restarts the ramp before moving.
  assign dir_new  = mv_up ? DIR_UP : DIR_DN;
  assign dir_chg  = (dir_new != dir_q);
  assign stp_eff  = dir_chg ? SW'(1) : step_q;
  assign ramp_inc = (dir_chg ? '0 : ramp_q) + 1'b1;
  assign pos_sum  = {1'b0, vpos_q} + 9'(stp_eff);
  assign pos_dif  = {1'b0, vpos_q} - 9'(stp_eff);

`ifdef PADDLE_FILTER_EN
  // Arithmetic shift alone would stall a few units short; force a unit step.
  always_comb begin
    fdiff = $signed({1'b0, a}) - $signed({1'b0, vpos_q});
    fsh   = fdiff >>> 2;
    if (fsh == 9'sd0 && fdiff != 9'sd0) fsh = fdiff[8] ? -9'sd1 : 9'sd1;
  end
`endif

  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    src_d  = src_q;
    vpos_d = vpos_q;
    step_d = step_q;
    ramp_d = ramp_q;
    dir_d  = dir_q;
    aref_d = src_q ? aref_q : a;
    if (!src_q) begin
      step_d = SW'(1);
      ramp_d = '0;
      dir_d  = DIR_NONE;
      if (btn) begin
        src_d = 1'b1;
      end else begin
`ifdef PADDLE_FILTER_EN
        if (tick) vpos_d = vpos_q + fsh[7:0];
`else
        vpos_d = a;
`endif
      end
    end else begin
      if (!btn && dev_big) src_d = 1'b0;
      if (tick) begin
        if (!mv_up && !mv_dn) begin
          step_d = SW'(1);
          ramp_d = '0;
          dir_d  = DIR_NONE;
        end else begin
          if (mv_up) vpos_d = pos_dif[8] ? 8'h00 : pos_dif[7:0];
          else       vpos_d = pos_sum[8] ? 8'hFF : pos_sum[7:0];
          dir_d  = dir_new;
          step_d = stp_eff;
          ramp_d = ramp_inc;
          if (ramp_inc == RW'(RAMP_TICKS)) begin
            ramp_d = '0;
            if (stp_eff != SW'(ACCEL_MAX)) step_d = stp_eff + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      src_q  <= 1'b0;
      vpos_q <= 8'h80;
      step_q <= SW'(1);
      ramp_q <= '0;
      dir_q  <= DIR_NONE;
      aref_q <= 8'h80;
    end else begin
      cnt_q  <= cnt_d;
      src_q  <= src_d;
      vpos_q <= vpos_d;
      step_q <= step_d;
      ramp_q <= ramp_d;
      dir_q  <= dir_d;
      aref_q <= aref_d;
    end
  end

  assign vpos_out    = vpos_q;
  assign src_digital = src_q;

endmodule
